// File: rtl/vga_stream_timing_if.sv
// Pixel stream between the framebuffer reader (master) and the timing generator (slave).
interface vga_stream_timing_if #(
   parameter int RGB_W = 24
);
   logic [RGB_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_stream_timing.sv
// Parametrised VGA/LCD timing generator pulling pixels from a valid/ready stream.
// Optional macro VGA_STREAM_PATTERN_EN: underflow pixels show a 16-pixel grid instead of black.
module vga_stream_timing #(
   parameter int   HDISP  = 800,
   parameter int   VDISP  = 480,
   parameter int   HFP    = 40,
   parameter int   HPULSE = 48,
   parameter int   HBP    = 40,
   parameter int   VFP    = 13,
   parameter int   VPULSE = 3,
   parameter int   VBP    = 29,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0,
   parameter int   RGB_W  = 24,
   localparam int  XW     = (HDISP > 1) ? $clog2(HDISP) : 1,
   localparam int  YW     = (VDISP > 1) ? $clog2(VDISP) : 1
) (
   input  logic                pixel_clk,
   input  logic                pixel_rst,
   vga_stream_timing_if.slave  pix,
   output logic                HS,
   output logic                VS,
   output logic                BLANK,
   output logic [RGB_W-1:0]    RGB,
   output logic [XW-1:0]       x_pos,
   output logic [YW-1:0]       y_pos,
   output logic                frame_start,
   output logic                underflow
);

   localparam int HTOT = HFP + HPULSE + HBP + HDISP;
   localparam int VTOT = VFP + VPULSE + VBP + VDISP;
   localparam int HW   = $clog2(HTOT);
   localparam int VW   = $clog2(VTOT);

   localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
   localparam logic [HW-1:0] H_START  = HW'(HTOT - HDISP);
   localparam logic [HW-1:0] HP_BEGIN = HW'(HFP);
   localparam logic [HW-1:0] HP_END   = HW'(HFP + HPULSE);
   localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);
   localparam logic [VW-1:0] V_START  = VW'(VTOT - VDISP);
   localparam logic [VW-1:0] VP_BEGIN = VW'(VFP);
   localparam logic [VW-1:0] VP_END   = VW'(VFP + VPULSE);

   if (HDISP < 1 || VDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
       VFP < 1 || VPULSE < 1 || VBP < 1) begin : g_bad_param
      $error("vga_stream_timing: porch, pulse and display parameters must be >= 1");
   end

   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   logic             active;
   logic             h_pulse;
   logic             v_pulse;
   logic [RGB_W-1:0] fill;

   // NOTE: all sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Gated by reset so the source never sees a request while timing is restarting.
   assign active  = (h_cnt >= H_START) && (v_cnt >= V_START) && !pixel_rst;
   assign h_pulse = (h_cnt >= HP_BEGIN) && (h_cnt < HP_END);
   assign v_pulse = (v_cnt >= VP_BEGIN) && (v_cnt < VP_END);

   assign pix.pix_ready = active;
   assign x_pos = active ? XW'(h_cnt - H_START) : '0;
   assign y_pos = active ? YW'(v_cnt - V_START) : '0;

`ifdef VGA_STREAM_PATTERN_EN
   localparam int XPW = (XW < 4) ? XW : 4;
   localparam int YPW = (YW < 4) ? YW : 4;
   logic grid;

   // Low nibble zero means the coordinate is a multiple of 16.
   assign grid = (x_pos[XPW-1:0] == '0) || (y_pos[YPW-1:0] == '0);
   assign fill = {RGB_W{grid}};
`else
   assign fill = '0;
`endif

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         HS          <= ~HS_POL;
         VS          <= ~VS_POL;
         BLANK       <= 1'b0;
         RGB         <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         HS          <= h_pulse ? HS_POL : ~HS_POL;
         VS          <= v_pulse ? VS_POL : ~VS_POL;
         BLANK       <= active;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         if (active && !pix.pix_valid) begin
            underflow <= 1'b1;
         end
         if (!active) begin
            RGB <= '0;
         end else if (pix.pix_valid) begin
            RGB <= pix.pix_data;
         end else begin
            RGB <= fill;
         end
      end
   end

endmodule

// File: doc/vga_stream_timing.md
Name: vga_stream_timing

Overview:
- Parametrised VGA/LCD timing generator, successor to the fixed 800x480 generator.
- Generates HS/VS/BLANK from configurable porch, pulse and polarity parameters.
- Pulls pixels from an upstream stream source (framebuffer reader FIFO) through a valid/ready handshake, and drives RGB aligned with the sync signals.
- Reports stream underflow and frame/line boundaries to the rest of the video pipeline.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, HS pulse width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, VS pulse width (lines)
- VBP, 29, vertical back porch (lines)
- HS_POL, 0, HS level during the pulse (0 = active-low)
- VS_POL, 0, VS level during the pulse (0 = active-low)
- RGB_W, 24, pixel data width

Ports:
- pixel_clk  in  1  pixel clock, only clock of the block
- pixel_rst  in  1  synchronous reset, active-high
- pix_data  in  RGB_W  upstream pixel
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  pixel consumed this cycle
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- BLANK  out  1  1 = active display, 0 = blanking
- RGB  out  RGB_W  pixel to panel
- x_pos  out  clog2(HDISP)  column of the pixel requested this cycle
- y_pos  out  clog2(VDISP)  row of the pixel requested this cycle
- frame_start  out  1  one-cycle pulse at h=0, v=0
- underflow  out  1  sticky; set when ready && !valid

Behaviour:
- HTOT = HFP+HPULSE+HBP+HDISP; VTOT = VFP+VPULSE+VBP+VDISP.
- Counter widths are clog2(HTOT) and clog2(VTOT).
- h_cnt runs 0..HTOT-1 every cycle and wraps to 0.
- v_cnt increments only when h_cnt = HTOT-1, and wraps from VTOT-1 to 0 at that same cycle.
- Horizontal order: front porch [0,HFP), pulse [HFP,HFP+HPULSE), back porch, then display [HTOT-HDISP,HTOT). Vertical order is identical, using the V parameters.
- active = (h_cnt >= HTOT-HDISP) && (v_cnt >= VTOT-VDISP).
- pix_ready = active. This is combinational from the counters and independent of pix_valid.
- x_pos = h_cnt-(HTOT-HDISP) and y_pos = v_cnt-(VTOT-VDISP) when active; both are 0 otherwise.
- HS, VS, BLANK and RGB are registered, with 1-cycle latency from the counters, so RGB is aligned with its BLANK=1 cycle.
- HS = HS_POL inside the H pulse window, ~HS_POL elsewhere. VS is the same using VS_POL.
- BLANK = registered active.
- RGB = pix_data when active && pix_valid.
- RGB = 0 when active && !pix_valid; underflow is set and stays 1 until reset.
- RGB = 0 when not active.
- frame_start is registered and pulses in the cycle after h_cnt=0 && v_cnt=0.
- Reset values: h_cnt=0, v_cnt=0, HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, frame_start=0, underflow=0. pix_ready and x_pos/y_pos are 0 during reset.
- Reset mid-frame restarts timing at h=0, v=0 on the next cycle. The upstream source must flush on reset.
- A pix_valid asserted while not active is not consumed and does not trigger underflow.
- Elaboration check: all porch, pulse and display parameters must be >= 1.

Optional Feature:
- Macro: VGA_STREAM_PATTERN_EN.
- When defined, an underflow cycle outputs the grid pattern in place of 0: all-ones when x_pos%16==0 || y_pos%16==0, otherwise 0. underflow is still set.
- Not defined: RGB=0 on underflow. No pattern logic is synthesised.

Test Plan:
- Defaults, pix_valid=1 held: HS period 928 cycles, HS low 48 cycles starting at h=40; VS low for exactly 3 lines (2784 cycles); BLANK=1 for 800 cycles per line on 480 lines; frame_start every 487200 cycles.
- HDISP=4, VDISP=2, porches/pulses=1, pix_data=x_pos: RGB sequence 0,1,2,3 appears on the cycle after pix_ready, aligned with BLANK=1, on both active lines.
- pix_valid deasserted for one active cycle: underflow rises the next cycle and holds; RGB=0 for that pixel (pattern value with VGA_STREAM_PATTERN_EN at x=0 → all-ones).
- HS_POL=1, VS_POL=1: pulses are high, idle levels are low, reset levels are low.
- pixel_rst asserted at h=100, v=200 for 1 cycle: next cycle h=0, v=0, all outputs at reset values, underflow cleared; frame_start pulses one cycle after release.
- pix_valid=1 during blanking: pix_ready stays 0 and underflow stays 0.
